// File: rtl/spi_pkg.sv
// Shared SPI definitions: default frame geometry and the IDLE/ACTIVE state
// encoding used by both the responder and the master.
package spi_pkg;

    localparam int SPI_DATA_WIDTH  = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer for one asynchronous bus input, followed by a single
// history flop so rising/falling edges of the synchronized level can be
// detected without adding metastability exposure.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              hist_q;
    logic              hist_d;

    // Shift the pin level down the chain; history holds the previous output.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
        hist_d = sync_q[STAGES-1];
    end

    // Chain and history reset to the bus idle level so no false edge appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~hist_q;
    assign fall = ~q & hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder running entirely in the clk domain.
// Bit order: MSB first by default; define SPI_SLAVE_LSB_FIRST_EN for LSB first
// on both mosi and miso.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// SPI_IDLE   | cs high; miso held 0, spi_clk edges ignored
// SPI_ACTIVE | frame in progress; shift on synchronized spi_clk edges
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_clk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_done,
    output logic                  tx_done,
    output logic                  busy
);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d_in(spi_clk),
        .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d_in(cs),
        .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d_in(mosi),
        .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_e            state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  miso_q, miso_d;
    logic                  rx_done_q, rx_done_d;
    logic                  tx_done_q, tx_done_d;
    logic                  byte_seen_q, byte_seen_d;
    logic [DATA_WIDTH-1:0] rx_next;
    logic                  tx_first;
    logic                  tx_second;

    // Order-dependent views of the shift registers.
    always_comb begin
        rx_next   = LSB_FIRST ? {mosi_s, rx_sh_q[DATA_WIDTH-1:1]}
                              : {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
        tx_first  = LSB_FIRST ? tx_data[0] : tx_data[DATA_WIDTH-1];
        tx_second = LSB_FIRST ? tx_sh_q[1] : tx_sh_q[DATA_WIDTH-2];
    end

    // Next-state and datapath; cs rising takes priority over any spi_clk edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        rx_data_d   = rx_data_q;
        miso_d      = miso_q;
        rx_done_d   = 1'b0;
        tx_done_d   = 1'b0;
        byte_seen_d = byte_seen_q;
        case (state_q)
            SPI_IDLE: begin
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                if (cs_fall) begin
                    state_d     = SPI_ACTIVE;
                    tx_sh_d     = tx_data;
                    miso_d      = tx_first;
                    rx_sh_d     = '0;
                    byte_seen_d = 1'b0;
                end
            end
            SPI_ACTIVE: begin
                if (cs_rise) begin
                    state_d   = SPI_IDLE;
                    miso_d    = 1'b0;
                    bit_cnt_d = '0;
                end else if (sclk_rise) begin
                    rx_sh_d = rx_next;
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d   = rx_next;
                        rx_done_d   = 1'b1;
                        tx_done_d   = 1'b1;
                        bit_cnt_d   = '0;
                        byte_seen_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q != '0) begin
                        miso_d  = tx_second;
                        tx_sh_d = LSB_FIRST ? {1'b0, tx_sh_q[DATA_WIDTH-1:1]}
                                            : {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
                    end else if (byte_seen_q) begin
                        tx_sh_d = tx_data;
                        miso_d  = tx_first;
                    end
                end
            end
            default: state_d = SPI_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SPI_IDLE;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            rx_data_q   <= '0;
            miso_q      <= 1'b0;
            rx_done_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            byte_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            rx_data_q   <= rx_data_d;
            miso_q      <= miso_d;
            rx_done_q   <= rx_done_d;
            tx_done_q   <= tx_done_d;
            byte_seen_q <= byte_seen_d;
        end
    end

    assign miso    = miso_q;
    assign rx_data = rx_data_q;
    assign rx_done = rx_done_q;
    assign tx_done = tx_done_q;
    assign busy    = (state_q == SPI_ACTIVE);

endmodule
